// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   MULTU/MULT use a WIDTH-step shift-add; DIVU/DIV use a WIDTH-step
//   restoring divide on operand magnitudes with sign fix-up at the end.
//   HI/LO are written only in the FIXUP state, so partial results never
//   leak out. MFHI/MFLO reads that arrive while busy are interlocked via stall.
//
//   Optional build macro: MULDIV_FAST_MULT_EN
//     defined   -> MULT/MULTU use one combinational multiply and skip CALC
//                  (result and done appear one edge after the start edge).
//     undefined -> every op is iterative; no multiplier is inferred.
//
// Ports
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   request strobe, qualified by valid_ex
//   valid_ex  in   instruction in execute is valid
//   op        in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val    in   operand A (multiplicand / dividend)
//   rt_val    in   operand B (multiplier / divisor)
//   flush     in   cancel any in-flight operation (wins over start)
//   hilo_rd   in   execute holds an MFHI/MFLO
//   busy      out  operation in flight
//   done      out  one-cycle pulse, HI/LO just updated
//   stall     out  hilo_rd & busy (combinational)
//   hi, lo    out  HI/LO registers
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             valid_ex,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             hilo_we;
  logic             accept;

  // Operand / iteration datapath (no reset: only meaningful once accepted)
  logic [WIDTH-1:0]   a_q;      // |rs| (or rs for unsigned ops)
  logic [WIDTH-1:0]   b_q;      // |rt| (or rt for unsigned ops)
  logic [WIDTH-1:0]   rs_q;     // original rs, needed for divide-by-zero HI
  logic               is_div_q;
  logic               neg_q;    // product / quotient must be negated
  logic               rneg_q;   // remainder must be negated
  logic [2*WIDTH-1:0] acc_q;    // {partial hi / remainder, multiplier / quotient}
  logic [2*WIDTH-1:0] prod_raw;

  // Magnitude of a possibly-signed operand.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic             n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] x,
                                                     input logic               n);
    return n ? -x : x;
  endfunction

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right
  // (the extra sum bit carries into the top).
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   a);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder, trial-subtract the divisor and keep the result if it did not
  // borrow. The quotient bit fills in from the bottom as dividend bits leave.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   b);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, b};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  assign accept = (state_q == S_IDLE) && start && valid_ex && !flush;

  // ---- FSM state register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // ---- FSM next-state logic ----
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            count_d = '0;
`ifdef MULDIV_FAST_MULT_EN
            state_d = op[1] ? S_CALC : S_FIXUP;
`else
            state_d = S_CALC;
`endif
          end
        end
        S_CALC: begin
          count_d = count_q + CW'(1);
          if (count_q == LAST) state_d = S_FIXUP;
        end
        S_FIXUP: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- FSM outputs ----
  always_comb begin
    busy    = (state_q != S_IDLE);
    stall   = hilo_rd && (state_q != S_IDLE);
    hilo_we = (state_q == S_FIXUP) && !flush;
    done_d  = hilo_we;
  end

`ifdef MULDIV_FAST_MULT_EN
  assign prod_raw = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
  assign prod_raw = acc_q;
`endif

  // Sign correction and special cases, consumed only in FIXUP.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!is_div_q) begin
      {hi_d, lo_d} = cond_neg_dw(prod_raw, neg_q);
    end else if (b_q == '0) begin
      lo_d = '1;
      hi_d = rs_q;
    end else begin
      // Most-negative / -1 falls out naturally: magnitude quotient is
      // 2^(WIDTH-1), whose negation is itself.
      lo_d = cond_neg_w(acc_q[WIDTH-1:0], neg_q);
      hi_d = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
    end
  end

  // ---- result registers ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (hilo_we) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  // ---- operand latch / iteration ----
  always_ff @(posedge clock) begin
    if (accept) begin
      a_q      <= mag(rs_val, op[0]);
      b_q      <= mag(rt_val, op[0]);
      rs_q     <= rs_val;
      is_div_q <= op[1];
      neg_q    <= op[0] && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      rneg_q   <= op[0] && rs_val[WIDTH-1];
      acc_q    <= {{WIDTH{1'b0}}, op[1] ? mag(rs_val, op[0]) : mag(rt_val, op[0])};
    end else if (state_q == S_CALC) begin
      acc_q <= is_div_q ? div_step(acc_q, b_q) : mul_step(acc_q, a_q);
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W     = 32;
  localparam int LAT_D = 33;
`ifdef MULDIV_FAST_MULT_EN
  localparam int LAT_M = 1;
`else
  localparam int LAT_M = 33;
`endif

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          valid_ex;
  logic [1:0]    op;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  rt_val;
  logic          flush;
  logic          hilo_rd;
  logic          busy;
  logic          done;
  logic          stall;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .valid_ex (valid_ex),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .hilo_rd  (hilo_rd),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge (E0), then drop it.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    valid_ex = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    step();
    start    = 1'b0;
    valid_ex = 1'b0;
  endtask

  // Edges advanced until done is seen, bounded at 40.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hilo_rd = 1'b1;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset_n = 1'b1;
    hilo_rd = 1'b0;
    step();
  endtask

  task automatic test_divu();
    int n;
    issue(2'b10, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy_e0: got %b want 1", busy); end
    wait_done(n);
    checks++; if (n != LAT_D) begin errors++; $display("FAIL divu_latency: got %0d want %0d", n, LAT_D); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want %h", hi, 32'd2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_done: got %b want 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div_signed();
    int n;
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);  // -7 / 2
    wait_done(n);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    step();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);  // most-negative / -1
    wait_done(n);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
    step();
  endtask

  task automatic test_div_zero();
    int n;
    issue(2'b10, 32'd5, 32'd0);
    wait_done(n);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu0_hi: got %h want 5", hi); end
    step();
    issue(2'b11, 32'hFFFF_FFFB, 32'd0);  // -5 / 0
    wait_done(n);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_hi: got %h want fffffffb", hi); end
    step();
  endtask

  task automatic test_mult();
    int n;
    issue(2'b01, 32'hFFFF_FFFD, 32'd4);  // -3 * 4
    wait_done(n);
    checks++; if (n != LAT_M) begin errors++; $display("FAIL mult_latency: got %0d want %0d", n, LAT_M); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mult_lo: got %h want fffffff4", lo); end
    step();
    issue(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA);  // -5 * -6
    wait_done(n);
    checks++; if ({hi, lo} !== 64'd30) begin errors++; $display("FAIL mult_negneg: got %h want %h", {hi, lo}, 64'd30); end
    step();
    issue(2'b00, 32'd7, 32'd6);
    wait_done(n);
    checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL multu_small: got %h want %h", {hi, lo}, 64'd42); end
    step();
  endtask

  task automatic test_stall();
    int n;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hilo_rd = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
      if (n < LAT_M) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_inflight: got %b want 1 at E%0d", stall, n); end
      end
    end
    checks++; if (n != LAT_M) begin errors++; $display("FAIL stall_latency: got %0d want %0d", n, LAT_M); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle: got %b want 0", stall); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h1) begin errors++; $display("FAIL multu_max_lo: got %h want 1", lo); end
    hilo_rd = 1'b0;
    step();
  endtask

  task automatic test_flush();
    int ndone;
    issue(2'b10, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) step();
    flush    = 1'b1;
    start    = 1'b1;
    valid_ex = 1'b1;
    op       = 2'b00;
    rs_val   = 32'd3;
    rt_val   = 32'd3;
    step();  // E10
    flush    = 1'b0;
    start    = 1'b0;
    valid_ex = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b want 0", busy); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL flush_no_done: got %0d want 0", ndone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_ignored: got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_hi_kept: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h1) begin errors++; $display("FAIL flush_lo_kept: got %h want 1", lo); end
  endtask

  task automatic test_start_busy();
    int n;
    int ndone;
    issue(2'b10, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) step();
    start    = 1'b1;
    valid_ex = 1'b1;
    op       = 2'b00;
    rs_val   = 32'd9;
    rt_val   = 32'd9;
    step();
    start    = 1'b0;
    valid_ex = 1'b0;
    wait_done(n);
    checks++; if (n != LAT_D - 4) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", n, LAT_D - 4); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_start_lo: got %h want e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busy_start_hi: got %h want 2", hi); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL busy_start_dropped: got %0d extra done want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(2'b10, 32'd100, 32'd7);
    wait_done(n);
    hilo_rd = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_read_stall: got %b want 0", stall); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_read_lo: got %h want e", lo); end
    hilo_rd = 1'b0;
    issue(2'b00, 32'd6, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy); end
    wait_done(n);
    checks++; if (n != LAT_M) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", n, LAT_M); end
    checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL b2b_result: got %h want %h", {hi, lo}, 64'd42); end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    issue(2'b10, 32'd200, 32'd3);
    for (int i = 0; i < 4; i++) step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
    #1 reset_n = 1'b1;
    step();
    issue(2'b10, 32'd200, 32'd3);
    wait_done(n);
    checks++; if (n != LAT_D) begin errors++; $display("FAIL rstmid_restart_latency: got %0d want %0d", n, LAT_D); end
    checks++; if (lo !== 32'd66) begin errors++; $display("FAIL rstmid_restart_lo: got %h want 42", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL rstmid_restart_hi: got %h want 2", hi); end
    step();
  endtask

  initial begin
    start    = 1'b0;
    valid_ex = 1'b0;
    op       = 2'b00;
    rs_val   = '0;
    rt_val   = '0;
    flush    = 1'b0;
    hilo_rd  = 1'b0;
    reset_n  = 1'b0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_mult();
    test_stall();
    test_flush();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
